instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Sits directly downstream of the program counter, between the PC's IMADDR output and the instruction memory.
- On a FETCH request from the control unit, it latches the current PC address and issues a read strobe to instruction memory. It then waits a variable number of cycles for the response.
- It captures the returned word into an instruction register and presents it to the control unit with a valid/ack handshake.
- It pulses PC_INC so the PC advances exactly once per delivered instruction, and supports FLUSH on branches plus a memory-timeout flag.

Parameters:
- ADDR_W, 16, instruction address width; must match the PC width.
- INSTR_W, 16, instruction word width.
- MAX_WAIT, 8, number of WAIT-state cycles without IM_VALID before the fetch is abandoned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IMADDR  in  ADDR_W  current PC value.
- FETCH  in  1  control unit requests the next instruction.
- FLUSH  in  1  branch/jump: PC is being rewritten; abort or discard the current fetch.
- IM_RD  out  1  one-cycle read strobe to instruction memory.
- IM_ADDR  out  ADDR_W  address latched for the read.
- IM_DATA  in  INSTR_W  memory read data.
- IM_VALID  in  1  IM_DATA valid this cycle.
- INS  out  INSTR_W  instruction register.
- INS_VALID  out  1  INS holds an unconsumed instruction.
- INS_ACK  in  1  control unit consumes INS.
- PC_INC  out  1  one-cycle pulse driving the PC's INC input.
- BUSY  out  1  high in REQ and WAIT.
- TIMEOUT  out  1  sticky: memory failed to respond.

Behaviour:
- Reset (async, rst_n=0) sets every output to zero:
  - state=IDLE; IM_RD, IM_ADDR, INS, INS_VALID, PC_INC, TIMEOUT all 0.
  - Internal discard flag and wait counter are cleared.
- All outputs are registered.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - FETCH=1 and FLUSH=0: IM_ADDR<=IMADDR, IM_RD<=1, go to REQ.
  - Otherwise stay in IDLE.
- REQ (IM_RD high exactly this one cycle):
  - Next cycle IM_RD<=0, wait counter cleared, go to WAIT.
  - IM_VALID is ignored in REQ.
- WAIT:
  - IM_VALID=1 with discard=1: clear discard, remain in WAIT (the stale response is dropped).
  - IM_VALID=1 with discard=0: INS<=IM_DATA, INS_VALID<=1, PC_INC<=1 for one cycle, go to HOLD.
  - No IM_VALID: counter increments. At MAX_WAIT: TIMEOUT<=1, discard<=1 (a late response must be dropped), go to IDLE.
- Minimum latency:
  - FETCH sampled at edge 0 gives IM_RD high after edge 0.
  - Earliest accepted IM_VALID is sampled at edge 2.
  - INS_VALID and PC_INC are high after edge 2.
- HOLD:
  - INS and INS_VALID are held stable until INS_ACK; FETCH is ignored while INS_ACK=0.
  - INS_ACK=1: INS_VALID<=0. If FETCH=1 in the same cycle, latch IMADDR, IM_RD<=1 and go to REQ (back-to-back fetch). Otherwise go to IDLE.
- FLUSH has priority over every other input:
  - In REQ or WAIT: go to IDLE and set discard=1. The exception is WAIT when the sampled IM_VALID=1 and discard=0: the response is consumed and dropped, so discard stays 0.
  - In HOLD: INS_VALID<=0, go to IDLE.
  - PC_INC is never asserted in a cycle following a sampled FLUSH=1. Coincident IM_VALID and FLUSH produces no PC_INC and no INS_VALID.
- Discard flag: at most one outstanding stale response is tracked. A FETCH accepted while discard=1 proceeds normally; the first IM_VALID in its WAIT is dropped.
- TIMEOUT is sticky until reset and does not block further fetches.
- INS is not cleared on ACK or FLUSH; only INS_VALID qualifies it.
- Reset mid-fetch: return to IDLE immediately, IM_RD drops asynchronously, and a later IM_VALID is ignored because IDLE never samples it.

Decomposition:
- Shared package/header ifu_defs holds:
  - state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3);
  - default widths;
  - CNT_W = clog2(MAX_WAIT+1).
- One sub-module, ifu_wait_timer: clear/enable counter with terminal-count output at MAX_WAIT.
- The FSM and datapath stay in instr_fetch_unit.

Test Plan:
- Basic fetch:
  - Stimulus: IMADDR=16'h0010, FETCH for 1 cycle; memory returns IM_DATA=16'hA5C3 two cycles after IM_RD.
  - Response: IM_ADDR=16'h0010; IM_RD high 1 cycle; INS=16'hA5C3 with INS_VALID; PC_INC is exactly one 1-cycle pulse.
- Hold/back-to-back:
  - Stimulus: INS_ACK withheld for 5 cycles, then INS_ACK together with FETCH and IMADDR=16'h0011.
  - Response: INS stable for 5 cycles; no PC_INC while waiting; REQ starts on the following cycle with IM_ADDR=16'h0011.
- Timeout:
  - Stimulus: MAX_WAIT=8, no IM_VALID.
  - Response: after 8 WAIT cycles TIMEOUT=1 and state=IDLE. An IM_VALID with 16'hFFFF one cycle later is dropped: no INS_VALID, no PC_INC.
- Flush in WAIT:
  - Stimulus: FLUSH asserted 1 cycle after IM_RD; new FETCH at IMADDR=16'h0040; memory returns stale 16'h1111, then 16'h2222.
  - Response: INS=16'h2222; exactly one PC_INC for the whole sequence.
- Coincident FLUSH and IM_VALID:
  - Stimulus: FLUSH and IM_VALID (16'h3333) in the same cycle.
  - Response: no INS_VALID, no PC_INC, discard stays 0. A next fetch returning 16'h4444 is delivered normally.
- Async reset:
  - Stimulus: rst_n low mid-WAIT, between clock edges.
  - Response: all outputs 0 immediately; after release, a FETCH behaves as in the first scenario.

Source files
------------

// File: rtl/ifu_defs_pkg.sv
// Shared definitions for the instruction fetch unit.
// State encodings, default widths and counter sizing.
package ifu_defs;

  localparam int ADDR_W_DEF   = 16;
  localparam int INSTR_W_DEF  = 16;
  localparam int MAX_WAIT_DEF = 8;

  localparam int CNT_W = $clog2(MAX_WAIT_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  function automatic int cnt_width(int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: PC input, memory side, control side.
// slave is the fetch unit, master is its environment.
interface instr_fetch_unit_if
  import ifu_defs::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic [ADDR_W-1:0]  IMADDR;
  logic               FETCH;
  logic               FLUSH;
  logic               IM_RD;
  logic [ADDR_W-1:0]  IM_ADDR;
  logic [INSTR_W-1:0] IM_DATA;
  logic               IM_VALID;
  logic [INSTR_W-1:0] INS;
  logic               INS_VALID;
  logic               INS_ACK;
  logic               PC_INC;
  logic               BUSY;
  logic               TIMEOUT;

  modport slave (
    input  IMADDR,
    input  FETCH,
    input  FLUSH,
    input  IM_DATA,
    input  IM_VALID,
    input  INS_ACK,
    output IM_RD,
    output IM_ADDR,
    output INS,
    output INS_VALID,
    output PC_INC,
    output BUSY,
    output TIMEOUT
  );

  modport master (
    output IMADDR,
    output FETCH,
    output FLUSH,
    output IM_DATA,
    output IM_VALID,
    output INS_ACK,
    input  IM_RD,
    input  IM_ADDR,
    input  INS,
    input  INS_VALID,
    input  PC_INC,
    input  BUSY,
    input  TIMEOUT
  );

endinterface

// File: rtl/ifu_wait_timer.sv
// Wait-state counter with synchronous clear.
// tc flags the cycle whose increment reaches MAX_WAIT.
module ifu_wait_timer #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt;

  // count wait cycles; clear wins over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC latch, memory read,
// instruction register, flush and timeout handling.
module instr_fetch_unit
  import ifu_defs::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_unit_if.slave bus
);

  localparam int CW = cnt_width(MAX_WAIT);

  state_t             state;
  state_t             state_n;
  logic               rd_q;
  logic               rd_n;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_n;
  logic [INSTR_W-1:0] ins_q;
  logic [INSTR_W-1:0] ins_n;
  logic               vld_q;
  logic               vld_n;
  logic               inc_q;
  logic               inc_n;
  logic               to_q;
  logic               to_n;
  logic               disc_q;
  logic               disc_n;
  logic               clr;
  logic               en;
  logic               tc;

  // restart the count on entry to WAIT;
  // only idle WAIT cycles advance it
  assign clr = (state == REQ);
  assign en  = (state == WAIT)
            && !bus.FLUSH
            && !bus.IM_VALID;

  ifu_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (en),
    .tc    (tc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state and registered-output next values
  always_comb begin
    state_n = state;
    rd_n    = 1'b0;
    addr_n  = addr_q;
    ins_n   = ins_q;
    vld_n   = vld_q;
    inc_n   = 1'b0;
    to_n    = to_q;
    disc_n  = disc_q;
    unique case (state)
      IDLE: begin
        if (bus.FETCH && !bus.FLUSH) begin
          addr_n  = bus.IMADDR;
          rd_n    = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (bus.FLUSH) begin
          disc_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.FLUSH) begin
          state_n = IDLE;
          if (!(bus.IM_VALID && !disc_q)) begin
            disc_n = 1'b1;
          end
        end else if (bus.IM_VALID) begin
          if (disc_q) begin
            disc_n = 1'b0;
          end else begin
            ins_n   = bus.IM_DATA;
            vld_n   = 1'b1;
            inc_n   = 1'b1;
            state_n = HOLD;
          end
        end else if (tc) begin
          to_n    = 1'b1;
          disc_n  = 1'b1;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (bus.FLUSH) begin
          vld_n   = 1'b0;
          state_n = IDLE;
        end else if (bus.INS_ACK) begin
          vld_n = 1'b0;
          if (bus.FETCH) begin
            addr_n  = bus.IMADDR;
            rd_n    = 1'b1;
            state_n = REQ;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= 1'b0;
      addr_q <= '0;
      ins_q  <= '0;
      vld_q  <= 1'b0;
      inc_q  <= 1'b0;
      to_q   <= 1'b0;
      disc_q <= 1'b0;
    end else begin
      rd_q   <= rd_n;
      addr_q <= addr_n;
      ins_q  <= ins_n;
      vld_q  <= vld_n;
      inc_q  <= inc_n;
      to_q   <= to_n;
      disc_q <= disc_n;
    end
  end

  assign bus.IM_RD     = rd_q;
  assign bus.IM_ADDR   = addr_q;
  assign bus.INS       = ins_q;
  assign bus.INS_VALID = vld_q;
  assign bus.PC_INC    = inc_q;
  assign bus.TIMEOUT   = to_q;
  assign bus.BUSY      = (state == REQ)
                      || (state == WAIT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table,
// directed corner sequences and a random run.
module tb_instr_fetch_unit;
  import ifu_defs::*;

  localparam int AW = 16;
  localparam int IW = 16;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(
    .ADDR_W  (AW),
    .INSTR_W (IW)
  ) bus ();

  instr_fetch_unit #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .MAX_WAIT (MW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int inc_cnt = 0;

  // reference model: a fetch is either being
  // strobed, awaiting data, or parked for ack
  bit          m_strobe;
  bit          m_wait;
  bit          m_hold;
  bit          m_disc;
  int          m_cnt;
  logic [15:0] m_addr;
  logic [15:0] m_ins;
  bit          m_vld;
  bit          m_inc;
  bit          m_to;

  typedef struct {
    logic        f;
    logic        fl;
    logic        v;
    logic [15:0] d;
    logic [15:0] a;
    logic        ack;
    logic        rd;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] ins;
    logic        inc;
    logic        busy;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  name, got, exp);
  endtask

  task automatic model_reset();
    m_strobe = 0;
    m_wait   = 0;
    m_hold   = 0;
    m_disc   = 0;
    m_cnt    = 0;
    m_addr   = '0;
    m_ins    = '0;
    m_vld    = 0;
    m_inc    = 0;
    m_to     = 0;
  endtask

  task automatic model_step(input bit f,
                            input bit fl,
                            input bit v,
                            input logic [15:0] d,
                            input logic [15:0] a,
                            input bit ack);
    m_inc = 0;
    if (m_strobe) begin
      m_strobe = 0;
      if (fl) m_disc = 1;
      else begin
        m_wait = 1;
        m_cnt  = 0;
      end
    end else if (m_wait) begin
      if (fl) begin
        m_wait = 0;
        if (!(v && !m_disc)) m_disc = 1;
      end else if (v) begin
        if (m_disc) m_disc = 0;
        else begin
          m_ins  = d;
          m_vld  = 1;
          m_inc  = 1;
          m_wait = 0;
          m_hold = 1;
        end
      end else begin
        m_cnt++;
        if (m_cnt == MW) begin
          m_to   = 1;
          m_disc = 1;
          m_wait = 0;
        end
      end
    end else if (m_hold) begin
      if (fl) begin
        m_vld  = 0;
        m_hold = 0;
      end else if (ack) begin
        m_vld  = 0;
        m_hold = 0;
        if (f) begin
          m_addr   = a;
          m_strobe = 1;
        end
      end
    end else if (f && !fl) begin
      m_addr   = a;
      m_strobe = 1;
    end
  endtask

  task automatic mcheck();
    chk("m.rd", 32'(bus.IM_RD), 32'(m_strobe));
    chk("m.addr", 32'(bus.IM_ADDR), 32'(m_addr));
    chk("m.ins", 32'(bus.INS), 32'(m_ins));
    chk("m.vld", 32'(bus.INS_VALID), 32'(m_vld));
    chk("m.inc", 32'(bus.PC_INC), 32'(m_inc));
    chk("m.busy", 32'(bus.BUSY),
        32'(m_strobe || m_wait));
    chk("m.to", 32'(bus.TIMEOUT), 32'(m_to));
  endtask

  task automatic set_in(input bit f,
                        input bit fl,
                        input bit v,
                        input logic [15:0] d,
                        input logic [15:0] a,
                        input bit ack);
    bus.FETCH    = f;
    bus.FLUSH    = fl;
    bus.IM_VALID = v;
    bus.IM_DATA  = d;
    bus.IMADDR   = a;
    bus.INS_ACK  = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bus.FETCH, bus.FLUSH,
               bus.IM_VALID, bus.IM_DATA,
               bus.IMADDR, bus.INS_ACK);
    #1;
    inc_cnt += int'(bus.PC_INC);
    mcheck();
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rd"}, 32'(bus.IM_RD), 0);
    chk({tag, ".addr"}, 32'(bus.IM_ADDR), 0);
    chk({tag, ".ins"}, 32'(bus.INS), 0);
    chk({tag, ".vld"}, 32'(bus.INS_VALID), 0);
    chk({tag, ".inc"}, 32'(bus.PC_INC), 0);
    chk({tag, ".busy"}, 32'(bus.BUSY), 0);
    chk({tag, ".to"}, 32'(bus.TIMEOUT), 0);
  endtask

  initial begin
    // f fl v d a ack | rd addr vld ins inc busy
    tbl[0]  = '{1,0,0,16'h0,16'h0010,0,
                1,16'h0010,0,16'h0000,0,1};
    tbl[1]  = '{0,0,0,16'h0,16'h0000,0,
                0,16'h0010,0,16'h0000,0,1};
    tbl[2]  = '{0,0,1,16'hA5C3,16'h0,0,
                0,16'h0010,1,16'hA5C3,1,0};
    tbl[3]  = '{1,0,0,16'h0,16'h0055,0,
                0,16'h0010,1,16'hA5C3,0,0};
    tbl[4]  = '{0,0,0,16'h0,16'h0000,0,
                0,16'h0010,1,16'hA5C3,0,0};
    tbl[5]  = '{1,0,1,16'h9999,16'h0055,0,
                0,16'h0010,1,16'hA5C3,0,0};
    tbl[6]  = '{0,0,0,16'h0,16'h0000,0,
                0,16'h0010,1,16'hA5C3,0,0};
    tbl[7]  = '{0,0,0,16'h0,16'h0000,0,
                0,16'h0010,1,16'hA5C3,0,0};
    tbl[8]  = '{1,0,0,16'h0,16'h0011,1,
                1,16'h0011,0,16'hA5C3,0,1};
    tbl[9]  = '{0,0,0,16'h0,16'h0000,0,
                0,16'h0011,0,16'hA5C3,0,1};
    tbl[10] = '{0,0,1,16'h1234,16'h0,0,
                0,16'h0011,1,16'h1234,1,0};
    tbl[11] = '{0,0,0,16'h0,16'h0000,1,
                0,16'h0011,0,16'h1234,0,0};

    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    model_reset();
    #8;
    chk_zero("rst");
    rst_n = 1'b1;

    // basic fetch, hold and back-to-back
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].f, tbl[i].fl, tbl[i].v,
             tbl[i].d, tbl[i].a, tbl[i].ack);
      tick();
      chk($sformatf("v%0d.rd", i),
          32'(bus.IM_RD), 32'(tbl[i].rd));
      chk($sformatf("v%0d.addr", i),
          32'(bus.IM_ADDR), 32'(tbl[i].addr));
      chk($sformatf("v%0d.vld", i),
          32'(bus.INS_VALID), 32'(tbl[i].vld));
      chk($sformatf("v%0d.ins", i),
          32'(bus.INS), 32'(tbl[i].ins));
      chk($sformatf("v%0d.inc", i),
          32'(bus.PC_INC), 32'(tbl[i].inc));
      chk($sformatf("v%0d.busy", i),
          32'(bus.BUSY), 32'(tbl[i].busy));
    end

    // timeout after MW idle wait cycles
    do_reset();
    set_in(1, 0, 0, 16'h0, 16'h0070, 0);
    tick();
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();
    for (int k = 0; k < MW; k++) begin
      tick();
      if (k < MW - 1)
        chk("to.early", 32'(bus.TIMEOUT), 0);
    end
    chk("to.flag", 32'(bus.TIMEOUT), 1);
    chk("to.idle", 32'(bus.BUSY), 0);
    set_in(0, 0, 1, 16'hFFFF, 16'h0, 0);
    tick();
    chk("to.late.vld", 32'(bus.INS_VALID), 0);
    chk("to.late.inc", 32'(bus.PC_INC), 0);
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();

    // flush in WAIT, stale response dropped
    do_reset();
    inc_cnt = 0;
    set_in(1, 0, 0, 16'h0, 16'h0030, 0);
    tick();
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();
    set_in(0, 1, 0, 16'h0, 16'h0, 0);
    tick();
    chk("fl.idle", 32'(bus.BUSY), 0);
    set_in(1, 0, 0, 16'h0, 16'h0040, 0);
    tick();
    chk("fl.addr", 32'(bus.IM_ADDR), 16'h0040);
    chk("fl.rd", 32'(bus.IM_RD), 1);
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();
    set_in(0, 0, 1, 16'h1111, 16'h0, 0);
    tick();
    chk("fl.stale", 32'(bus.INS_VALID), 0);
    set_in(0, 0, 1, 16'h2222, 16'h0, 0);
    tick();
    chk("fl.ins", 32'(bus.INS), 16'h2222);
    chk("fl.vld", 32'(bus.INS_VALID), 1);
    set_in(0, 0, 0, 16'h0, 16'h0, 1);
    tick();
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();
    chk("fl.inc_cnt", 32'(inc_cnt), 1);

    // coincident flush and response
    do_reset();
    set_in(1, 0, 0, 16'h0, 16'h0020, 0);
    tick();
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();
    set_in(0, 1, 1, 16'h3333, 16'h0, 0);
    tick();
    chk("co.vld", 32'(bus.INS_VALID), 0);
    chk("co.inc", 32'(bus.PC_INC), 0);
    chk("co.busy", 32'(bus.BUSY), 0);
    set_in(1, 0, 0, 16'h0, 16'h0050, 0);
    tick();
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();
    set_in(0, 0, 1, 16'h4444, 16'h0, 0);
    tick();
    chk("co.ins", 32'(bus.INS), 16'h4444);
    chk("co.vld2", 32'(bus.INS_VALID), 1);
    chk("co.inc2", 32'(bus.PC_INC), 1);
    set_in(0, 0, 0, 16'h0, 16'h0, 1);
    tick();

    // async reset mid-WAIT, then mid-REQ
    set_in(1, 0, 0, 16'h0, 16'h0077, 0);
    tick();
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero("ar");
    #1;
    rst_n = 1'b1;
    set_in(1, 0, 0, 16'h0, 16'h0033, 0);
    tick();
    chk("ar.req", 32'(bus.IM_RD), 1);
    #2;
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar.rd_drop", 32'(bus.IM_RD), 0);
    #1;
    rst_n = 1'b1;
    set_in(1, 0, 0, 16'h0, 16'h0010, 0);
    tick();
    chk("ar.addr", 32'(bus.IM_ADDR), 16'h0010);
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();
    set_in(0, 0, 1, 16'hA5C3, 16'h0, 0);
    tick();
    chk("ar.ins", 32'(bus.INS), 16'hA5C3);
    chk("ar.inc", 32'(bus.PC_INC), 1);
    set_in(0, 0, 0, 16'h0, 16'h0, 1);
    tick();

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit f;
      bit fl;
      bit v;
      bit ack;
      f   = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 11) == 0);
      v   = ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 2) != 0);
      if ((i % 200) < 14) begin
        v  = 0;
        fl = 0;
      end
      set_in(f, fl, v,
             16'($urandom), 16'($urandom), ack);
      tick();
    end

    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule
